// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: buffers samples in a FIFO, issues them one at a time to the FIR core, holds each result for the reader.
// Defining FIR_SEQ_WDOG_EN adds a WAIT-state watchdog and the sticky wdog_err output.
module fir_seq_ctrl #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 19,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 63
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic                   s_valid,
    input  logic [DATA_W-1:0]      s_data,
    output logic                   s_ready,
    output logic                   fir_valid_in,
    output logic [DATA_W-1:0]      fir_x,
    input  logic                   fir_valid_out,
    input  logic [ACC_W-1:0]       fir_y,
    output logic                   m_valid,
    output logic [ACC_W-1:0]       m_data,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy,
    output logic                   ovf_err,
    input  logic                   err_clr
`ifdef FIR_SEQ_WDOG_EN
    ,
    output logic                   wdog_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
        $error("fir_seq_ctrl: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_nxt;
    logic              full, push, pop;
    logic              wdog_hit;

    assign full       = (count == CW'(DEPTH));
    assign s_ready    = ~full;
    assign push       = s_valid & ~full;
    assign pop        = fir_valid_in;
    assign count_nxt  = count + CW'(push) - CW'(pop);
    assign fifo_count = count;
    assign busy       = (state != IDLE) | (count != '0);

    always_ff @(posedge ACLK) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
        end
    end

`ifdef FIR_SEQ_WDOG_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wdog_cnt;

    // Counter sits at zero outside WAIT, so every WAIT entry starts a fresh window.
    assign wdog_hit = (state == WAIT) && !fir_valid_out && (wdog_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            wdog_cnt <= (state == WAIT) ? wdog_cnt + TW'(1) : '0;
            if (wdog_hit)     wdog_err <= 1'b1;
            else if (err_clr) wdog_err <= 1'b0;
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        fir_valid_in = 1'b0;
        m_valid      = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) state_nxt = ISSUE;
            end
            ISSUE: begin
                fir_valid_in = 1'b1;
                state_nxt    = WAIT;
            end
            WAIT: begin
                if (fir_valid_out) state_nxt = HOLD;
                else if (wdog_hit) state_nxt = IDLE;
            end
            HOLD: begin
                m_valid = 1'b1;
                if (m_ready) state_nxt = (count_nxt != '0) ? ISSUE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_nxt;
    end

    // Sample is latched on ISSUE entry; an empty FIFO here means it is being written this very cycle.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            fir_x  <= '0;
            m_data <= '0;
        end else begin
            if (state_nxt == ISSUE) fir_x <= (count == '0) ? s_data : mem[rd_ptr];
            if (state == WAIT && fir_valid_out) m_data <= fir_y;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)             ovf_err <= 1'b0;
        else if (s_valid && full) ovf_err <= 1'b1;
        else if (err_clr)         ovf_err <= 1'b0;
    end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Randomized self-checking bench for fir_seq_ctrl against a queue-based transaction model.
module tb_fir_seq_ctrl;

    localparam int DATA_W  = 8;
    localparam int ACC_W   = 19;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 63;

    logic                   ACLK = 1'b0;
    logic                   ARESETN;
    logic                   s_valid, s_ready, fir_valid_in, fir_valid_out;
    logic [DATA_W-1:0]      s_data, fir_x;
    logic [ACC_W-1:0]       fir_y, m_data;
    logic                   m_valid, m_ready, busy, ovf_err, err_clr;
    logic [$clog2(DEPTH):0] fifo_count;
`ifdef FIR_SEQ_WDOG_EN
    logic                   wdog_err;
`endif

    fir_seq_ctrl #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .fir_valid_in(fir_valid_in), .fir_x(fir_x),
        .fir_valid_out(fir_valid_out), .fir_y(fir_y),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .fifo_count(fifo_count), .busy(busy), .ovf_err(ovf_err), .err_clr(err_clr)
`ifdef FIR_SEQ_WDOG_EN
        , .wdog_err(wdog_err)
`endif
    );

    always #5 ACLK = ~ACLK;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: what is buffered, what is at the core, what result is held.
    logic [DATA_W-1:0] q[$];
    bit                m_free, m_issue, m_out, m_held, m_ovf, m_wdog;
    logic [ACC_W-1:0]  m_hval;
    logic [DATA_W-1:0] m_lastx;
`ifdef FIR_SEQ_WDOG_EN
    int                m_wait;
`endif

    // Core emulation and bookkeeping
    int               core_cnt;
    bit               core_en, core_fixed;
    int               lat_min, lat_max;
    logic [ACC_W-1:0] core_y, fixed_y;
    int               issue_seen;
    int               base;

    task automatic model_reset();
        q.delete();
        m_free  = 1'b1;
        m_issue = 1'b0;
        m_out   = 1'b0;
        m_held  = 1'b0;
        m_ovf   = 1'b0;
        m_wdog  = 1'b0;
        m_hval  = '0;
        m_lastx = '0;
`ifdef FIR_SEQ_WDOG_EN
        m_wait  = 0;
`endif
    endtask

    task automatic check_outputs();
        logic [DATA_W-1:0] exp_x;
        exp_x = (m_issue && q.size() != 0) ? q[0] : m_lastx;
        check_val("fir_valid_in", fir_valid_in, m_issue);
        check_val("fir_x", fir_x, exp_x);
        check_val("m_valid", m_valid, m_held);
        check_val("m_data", m_data, m_hval);
        check_val("s_ready", s_ready, q.size() < DEPTH);
        check_val("fifo_count", fifo_count, q.size());
        check_val("busy", busy, !m_free || q.size() != 0);
        check_val("ovf_err", ovf_err, m_ovf);
`ifdef FIR_SEQ_WDOG_EN
        check_val("wdog_err", wdog_err, m_wdog);
`endif
    endtask

    // Advance the model across the coming rising edge using the inputs presented now.
    task automatic model_edge();
        bit full, push, nxt_issue, wd_set;
        int size_before;
        size_before = q.size();
        full        = (size_before >= DEPTH);
        push        = s_valid && !full;
        nxt_issue   = 1'b0;
        wd_set      = 1'b0;
        if (m_issue) begin
            m_lastx = q.pop_front();
            m_out   = 1'b1;
`ifdef FIR_SEQ_WDOG_EN
            m_wait  = 0;
`endif
        end else if (m_free) begin
            if (size_before != 0) begin
                nxt_issue = 1'b1;
                m_free    = 1'b0;
            end
        end else if (m_out) begin
            if (fir_valid_out) begin
                m_out  = 1'b0;
                m_held = 1'b1;
                m_hval = fir_y;
            end
`ifdef FIR_SEQ_WDOG_EN
            else begin
                m_wait++;
                if (m_wait == TIMEOUT) begin
                    m_out  = 1'b0;
                    m_free = 1'b1;
                    wd_set = 1'b1;
                end
            end
`endif
        end else if (m_held && m_ready) begin
            m_held = 1'b0;
            if (size_before + int'(push) != 0) nxt_issue = 1'b1;
            else                               m_free    = 1'b1;
        end
        if (s_valid && full) m_ovf = 1'b1;
        else if (err_clr)    m_ovf = 1'b0;
        if (wd_set)          m_wdog = 1'b1;
        else if (err_clr)    m_wdog = 1'b0;
        if (push) q.push_back(s_data);
        m_issue = nxt_issue;
    endtask

    // One clock: check at the falling edge, advance the model, then drive the core response after the rising edge.
    task automatic cycle();
        @(negedge ACLK);
        if (!ARESETN) begin
            model_reset();
            core_cnt = 0;
        end
        check_outputs();
        if (fir_valid_in === 1'b1) issue_seen++;
        if (ARESETN) begin
            if (core_en && fir_valid_in === 1'b1) begin
                core_cnt = $urandom_range(lat_max, lat_min);
                core_y   = core_fixed ? fixed_y : ACC_W'($urandom);
            end
            model_edge();
        end
        @(posedge ACLK);
        #1;
        fir_valid_out = 1'b0;
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                fir_valid_out = 1'b1;
                fir_y         = core_y;
            end
        end
    endtask

    task automatic write_sample(input logic [DATA_W-1:0] v);
        s_valid = 1'b1;
        s_data  = v;
        cycle();
        s_valid = 1'b0;
    endtask

    initial begin
        s_valid = 1'b0; s_data = '0; fir_valid_out = 1'b0; fir_y = '0;
        m_ready = 1'b0; err_clr = 1'b0;
        core_cnt = 0; core_en = 1'b1; core_fixed = 1'b0; fixed_y = '0; core_y = '0;
        lat_min = 1; lat_max = 1; issue_seen = 0;
        model_reset();
        ARESETN = 1'b1;
        #2 ARESETN = 1'b0;
        @(posedge ACLK);
        #1;
        repeat (3) cycle();
        ARESETN = 1'b1;
        cycle();

        // Single sample, core answers 0x00123 after 4 cycles
        base = issue_seen;
        lat_min = 4; lat_max = 4; core_fixed = 1'b1; fixed_y = 19'h00123;
        write_sample(8'h05);
        repeat (12) cycle();
        check_val("t1_m_valid", m_valid, 1);
        check_val("t1_m_data", m_data, 32'h123);
        check_val("t1_fir_x", fir_x, 32'h05);
        m_ready = 1'b1;
        cycle();
        m_ready = 1'b0;
        repeat (4) cycle();
        check_val("t1_issues", issue_seen - base, 1);
        check_val("t1_busy", busy, 0);

        // Eight back-to-back writes, reader always ready
        base = issue_seen;
        core_fixed = 1'b0; lat_min = 1; lat_max = 3; m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) write_sample(DATA_W'(i));
        repeat (60) cycle();
        check_val("t2_issues", issue_seen - base, 8);
        check_val("t2_busy", busy, 0);

        // Core stalled: fill FIFO, overflow, clear, then drain
        base = issue_seen;
        core_en = 1'b0; m_ready = 1'b0;
        for (int i = 0; i < 10; i++) write_sample(DATA_W'(8'h11 + i));
        cycle();
        check_val("t3_ovf", ovf_err, 1);
        check_val("t3_s_ready", s_ready, 0);
        check_val("t3_count", fifo_count, DEPTH);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        check_val("t3_ovf_clr", ovf_err, 0);
        core_y = 19'h2ABCD;
        core_cnt = 1;
        core_en = 1'b1; m_ready = 1'b1;
        repeat (90) cycle();
        check_val("t3_issues", issue_seen - base, 9);
        check_val("t3_busy", busy, 0);

        // Pushes while a result is held and unread
        base = issue_seen;
        m_ready = 1'b0; lat_min = 2; lat_max = 2;
        write_sample(8'hA0);
        repeat (6) cycle();
        for (int i = 0; i < 3; i++) write_sample(DATA_W'(8'hB0 + i));
        repeat (7) cycle();
        check_val("t4_count", fifo_count, 3);
        check_val("t4_issues", issue_seen - base, 1);
        m_ready = 1'b1;
        repeat (40) cycle();
        check_val("t4_issues_all", issue_seen - base, 4);

        // Reset while waiting on the core with 3 samples queued, then a stray result
        core_en = 1'b0;
        for (int i = 0; i < 4; i++) write_sample(DATA_W'(8'hC0 + i));
        repeat (2) cycle();
        check_val("t5_count", fifo_count, 3);
        ARESETN = 1'b0;
        repeat (2) cycle();
        ARESETN = 1'b1;
        core_y = 19'h7FFFF;
        core_cnt = 1;
        repeat (5) cycle();
        check_val("t5_m_valid", m_valid, 0);
        check_val("t5_count0", fifo_count, 0);
        check_val("t5_busy", busy, 0);

        // Randomized traffic
        core_en = 1'b1; lat_min = 1; lat_max = 6;
        for (int i = 0; i < 1500; i++) begin
            s_valid = ($urandom_range(2, 0) == 0);
            s_data  = DATA_W'($urandom);
            m_ready = $urandom_range(1, 0) == 1;
            err_clr = ($urandom_range(49, 0) == 0);
            cycle();
        end
        s_valid = 1'b0; err_clr = 1'b0; m_ready = 1'b1;
        repeat (120) cycle();
        check_val("rand_busy", busy, 0);

`ifdef FIR_SEQ_WDOG_EN
        // Silent core: watchdog abandons the first sample and issues the next
        base = issue_seen;
        core_en = 1'b0;
        write_sample(8'h31);
        write_sample(8'h32);
        repeat (70) cycle();
        check_val("wd_err", wdog_err, 1);
        check_val("wd_issues", issue_seen - base, 2);
        core_y = 19'h01234;
        core_cnt = 1;
        repeat (5) cycle();
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        check_val("wd_clr", wdog_err, 0);
        core_en = 1'b1;
        repeat (5) cycle();
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
